cache_mem_responder: RTL and testbench
======================================

// Module: cache_mem_responder
// PURPOSE
//  Memory-side responder for the cache request interface (caches_if). Accepts single-word
//  requests from the icache (read-only) and dcache (read/write) ports and arbitrates them onto
//  one RAM port. It generates iwait/dwait and returns iload/dload, so it is the far end of
//  every fill and writeback the caches issue. One access is in flight at a time; RAM latency is variable.
// PARAMETERS
//  TIMEOUT  64   max cycles waiting for ram_rdy before the access is aborted as an error
//  ERR_WORD 32'hBAD1BAD1  load value returned on a timed-out read
// PORTS
//  CLK        in   1   clock; all state updates on rising edge
//  RST        in   1   reset; synchronous and active-high
//  iREN       in   1   icache read request
//  iaddr      in   32  icache word address (bits[1:0] ignored)
//  iwait      out  1   1 = icache request not yet satisfied
//  iload      out  32  icache read data, valid while iwait=0 and iREN=1
//  dREN       in   1   dcache read request
//  dWEN       in   1   dcache write request (dREN&dWEN together: treated as write)
//  daddr      in   32  dcache word address
//  dstore     in   32  dcache write data
//  dwait      out  1   1 = dcache request not yet satisfied
//  dload      out  32  dcache read data, valid while dwait=0 and dREN=1
//  ram_ren    out  1   RAM read strobe, held for the whole access
//  ram_wen    out  1   RAM write strobe, held for the whole access
//  ram_addr   out  32  RAM word address (latched request address)
//  ram_store  out  32  RAM write data (latched dstore)
//  ram_load   in   32  RAM read data, sampled when ram_rdy=1
//  ram_rdy    in   1   one-cycle pulse: RAM access complete
//  err        out  1   sticky: a RAM access timed out; cleared only by RST
// BEHAVIOUR
//  Reset: state=IDLE; ram_ren/ram_wen=0, ram_addr/ram_store=0, iload/dload=0, err=0,
//   last grant=I (so D wins the first tie). RST mid-access drops strobes on that edge; the
//   access is abandoned with no response.
//  Waits: iwait = iREN & ~(state==IDONE); dwait = (dREN|dWEN) & ~(state==DDONE). Combinational.
//  FSM states: IDLE, DACC, IACC, DDONE, IDONE.
//   IDLE: arbitrate. Only D pending -> DACC; only I pending -> IACC; both -> the port NOT granted
//    last (round-robin). On grant, latch addr (bits[1:0] forced 0), op, dstore; clear cycle counter.
//   DACC/IACC: drive ram_ren or ram_wen with the latched addr/data; counter +1 per cycle.
//    ram_rdy=1 -> capture ram_load into load reg; go to DDONE/IDONE; update last grant.
//    Counter reaches TIMEOUT-1 without ram_rdy -> drop strobes; err<=1; load reg<=ERR_WORD; go to DONE.
//   DDONE/IDONE: exactly one cycle; strobes low; dload/iload = load reg. Response is delivered
//    only if the requester still asserts the same op and same address as latched; otherwise the
//    result is discarded (wait stays 1) and the request is re-arbitrated. Next state IDLE always.
//  Latency: request seen in IDLE at edge N, ram_rdy at edge N+L -> wait=0 during cycle N+L+1.
//   Minimum request-to-response = 3 cycles (L=1). One idle cycle between consecutive accesses.
//  Request changes during DACC/IACC do not affect the RAM access in flight; a write is never aborted
//   except by timeout or RST.
//  ram_rdy arriving in IDLE/DONE is ignored.
//  iload/dload hold their last value outside DONE.
// STRUCTURE
//  cpu_types_pkg: word_t (32b), memctl_state_t enum (5 states, 3b), ERR_WORD default constant.
//  Sub-module mem_rr_arb: 2-requester round-robin grant (req[1:0], last, grant[1:0]), pure comb.
//  Top: FSM, request latches, timeout counter ($clog2(TIMEOUT) bits), load reg, wait logic.
// TESTING
//  D read 0x100, RAM rdy after 2 cycles with 0xDEADBEEF -> ram_ren high 2 cycles; dwait=0 and dload=0xDEADBEEF for exactly 1 cycle.
//  D write 0x204 data 0x12345678 -> ram_wen=1, ram_addr=0x204, ram_store=0x12345678 until rdy; dwait drops 1 cycle after rdy.
//  iREN and dREN both asserted continuously -> grants alternate D,I,D,I; neither waits >2 accesses.
//  dcache changes daddr 0x100->0x108 mid-DACC -> first read completes to RAM, no dwait drop; second access to 0x108 then served.
//  RAM never asserts rdy on I read -> after TIMEOUT=64 cycles: err=1, iwait=0 one cycle, iload=0xBAD1BAD1.
//  RST asserted in DACC cycle 2 -> next edge ram_ren=0, state IDLE, err=0, no dwait drop for the abandoned request.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/memory request path: word type, responder FSM states,
// default error load value and word alignment helper.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        DACC,
        IACC,
        DDONE,
        IDONE
    } memctl_state_t;

    localparam word_t ERR_WORD_DEFAULT = 32'hBAD1BAD1;

    // Word addresses ignore the byte offset bits.
    function automatic word_t word_align(input word_t a);
        return a & ~word_t'(32'h3);
    endfunction

endpackage

// File: rtl/mem_rr_arb.sv
// Two-requester round-robin arbiter. req[0]/grant[0] = icache, req[1]/grant[1] = dcache.
// last=1 means the dcache won the previous completed access, so a tie goes to the icache.
module mem_rr_arb (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder for the icache/dcache request interface: arbitrates single-word
// requests onto one variable-latency RAM port, one access in flight, with a RAM timeout.
module cache_mem_responder
    import cpu_types_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 64,
    parameter word_t       ERR_WORD = ERR_WORD_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ram_ren,
    output logic        ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_store,
    input  logic [31:0] ram_load,
    input  logic        ram_rdy,
    output logic        err
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    memctl_state_t state, next_state;

    word_t         addr_q;
    word_t         store_q;
    logic          wr_q;
    logic [CW-1:0] cnt_q;
    word_t         iload_q;
    word_t         dload_q;
    logic          err_q;
    logic          last_d_q;

    logic [1:0]    req;
    logic [1:0]    grant;
    logic          in_acc;
    logic          timeout_hit;
    logic          dmatch;
    logic          imatch;

    assign req = {dREN | dWEN, iREN};

    mem_rr_arb u_arb (
        .req   (req),
        .last  (last_d_q),
        .grant (grant)
    );

    assign in_acc      = (state == DACC) || (state == IACC);
    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

    // A finished access is only handed back if the requester still wants exactly it.
    assign dmatch = (wr_q ? dWEN : (dREN & ~dWEN)) && (word_align(daddr) == addr_q);
    assign imatch = iREN && (word_align(iaddr) == addr_q);

    assign iwait = iREN & ~((state == IDONE) & imatch);
    assign dwait = (dREN | dWEN) & ~((state == DDONE) & dmatch);

    assign ram_ren   = in_acc & ~wr_q;
    assign ram_wen   = in_acc & wr_q;
    assign ram_addr  = addr_q;
    assign ram_store = store_q;
    assign iload     = iload_q;
    assign dload     = dload_q;
    assign err       = err_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (grant[1]) begin
                    next_state = DACC;
                end else if (grant[0]) begin
                    next_state = IACC;
                end
            end
            DACC: begin
                if (ram_rdy || timeout_hit) begin
                    next_state = DDONE;
                end
            end
            IACC: begin
                if (ram_rdy || timeout_hit) begin
                    next_state = IDONE;
                end
            end
            DDONE, IDONE: next_state = IDLE;
            default:      next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q   <= '0;
            store_q  <= '0;
            wr_q     <= 1'b0;
            cnt_q    <= '0;
            iload_q  <= '0;
            dload_q  <= '0;
            err_q    <= 1'b0;
            last_d_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant[1]) begin
                        addr_q  <= word_align(daddr);
                        wr_q    <= dWEN;
                        store_q <= dstore;
                        cnt_q   <= '0;
                    end else if (grant[0]) begin
                        addr_q  <= word_align(iaddr);
                        wr_q    <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                DACC, IACC: begin
                    if (ram_rdy) begin
                        if (state == DACC) begin
                            dload_q <= ram_load;
                        end else begin
                            iload_q <= ram_load;
                        end
                        last_d_q <= (state == DACC);
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                        if (state == DACC) begin
                            dload_q <= ERR_WORD;
                        end else begin
                            iload_q <= ERR_WORD;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Self-checking bench for cache_mem_responder: a behavioural RAM with programmable latency,
// a directed vector table, multi-cycle corner sequences and randomized traffic vs. a memory model.
module tb_cache_mem_responder;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic        iwait, dwait;
    logic [31:0] iload, dload;
    logic        ram_ren, ram_wen, ram_rdy, err;
    logic [31:0] ram_addr, ram_store, ram_load;

    always #5 CLK = ~CLK;

    cache_mem_responder #(
        .TIMEOUT  (64),
        .ERR_WORD (32'hBAD1BAD1)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .iwait     (iwait),
        .iload     (iload),
        .dREN      (dREN),
        .dWEN      (dWEN),
        .daddr     (daddr),
        .dstore    (dstore),
        .dwait     (dwait),
        .dload     (dload),
        .ram_ren   (ram_ren),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_store (ram_store),
        .ram_load  (ram_load),
        .ram_rdy   (ram_rdy),
        .err       (err)
    );

    int nvec = 0;
    int nmis = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural RAM ----------------
    int    ram_lat = 1;          // 0 = never answers
    int    strobe_cnt = 0;       // strobe-high cycles of the most recent access
    word_t log_addr[$];
    bit    log_wr[$];
    word_t log_store[$];
    word_t ram_mem[word_t];
    word_t ref_mem[word_t];

    function automatic word_t dflt(input word_t a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic word_t ram_rd(input word_t a);
        return ram_mem.exists(a) ? ram_mem[a] : dflt(a);
    endfunction

    function automatic word_t ref_rd(input word_t a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    initial begin
        int cyc;
        cyc = 0;
        ram_rdy = 1'b0;
        ram_load = '0;
        forever begin
            @(negedge CLK);
            if (ram_ren || ram_wen) begin
                if (cyc == 0) begin
                    log_addr.push_back(ram_addr);
                    log_wr.push_back(ram_wen);
                    log_store.push_back(ram_store);
                end
                cyc++;
                strobe_cnt = cyc;
                if (ram_lat != 0 && cyc == ram_lat) begin
                    ram_rdy = 1'b1;
                    if (ram_wen) ram_mem[ram_addr] = ram_store;
                    else         ram_load = ram_rd(ram_addr);
                end else begin
                    ram_rdy = 1'b0;
                    ram_load = $urandom;
                end
            end else begin
                cyc = 0;
                ram_rdy = 1'b0;
                ram_load = $urandom;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic do_reset();
        @(posedge CLK); #1;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    task automatic do_access(input bit is_d, input bit wr, input word_t addr, input word_t wdata,
                             input int lat, output word_t load, output int cyc, output bit got);
        ram_lat = lat;
        load = '0;
        @(posedge CLK); #1;
        if (is_d) begin
            daddr = addr; dstore = wdata; dREN = !wr; dWEN = wr;
        end else begin
            iaddr = addr; iREN = 1'b1;
        end
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 200) begin
            @(negedge CLK);
            cyc++;
            if ((is_d ? dwait : iwait) == 1'b0) begin
                got = 1'b1;
                load = is_d ? dload : iload;
            end
        end
        if (got) begin
            @(negedge CLK);
            check("resp_one_cycle", is_d ? dwait : iwait, 1'b1);
            if (!wr) check("load_hold", is_d ? dload : iload, load);
        end
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    endtask

    typedef struct {
        bit    is_d;
        bit    wr;
        word_t addr;
        word_t wdata;
        int    lat;
        word_t exp_load;
        int    exp_cyc;
        int    exp_strobe;
        word_t exp_ram_addr;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tbl[8];
        word_t load;
        int    cyc;
        bit    got;
        int    n0;

        tbl[0] = '{1'b1, 1'b0, 32'h100, 32'h0,        2, 32'hDEADBEEF,  4,  2, 32'h100};
        tbl[1] = '{1'b1, 1'b1, 32'h204, 32'h12345678, 3, 32'h0,         5,  3, 32'h204};
        tbl[2] = '{1'b0, 1'b0, 32'h204, 32'h0,        1, 32'h12345678,  3,  1, 32'h204};
        tbl[3] = '{1'b1, 1'b0, 32'h207, 32'h0,        1, 32'h12345678,  3,  1, 32'h204};
        tbl[4] = '{1'b0, 1'b0, 32'h302, 32'h0,        4, 32'h0300FCFF,  6,  4, 32'h300};
        tbl[5] = '{1'b1, 1'b1, 32'h300, 32'hCAFEF00D, 1, 32'h0,         3,  1, 32'h300};
        tbl[6] = '{1'b1, 1'b0, 32'h300, 32'h0,        5, 32'hCAFEF00D,  7,  5, 32'h300};
        tbl[7] = '{1'b0, 1'b0, 32'h600, 32'h0,        0, 32'hBAD1BAD1, 66, 64, 32'h600};

        ram_mem[32'h100] = 32'hDEADBEEF;
        RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;
        do_reset();

        // ---- reset state ----
        @(negedge CLK);
        check("rst_ram_ren",   ram_ren,   1'b0);
        check("rst_ram_wen",   ram_wen,   1'b0);
        check("rst_ram_addr",  ram_addr,  32'h0);
        check("rst_ram_store", ram_store, 32'h0);
        check("rst_iload",     iload,     32'h0);
        check("rst_dload",     dload,     32'h0);
        check("rst_err",       err,       1'b0);
        check("rst_iwait",     iwait,     1'b0);
        check("rst_dwait",     dwait,     1'b0);

        // ---- directed vector table ----
        for (int i = 0; i < 8; i++) begin
            do_access(tbl[i].is_d, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].lat, load, cyc, got);
            check($sformatf("v%0d_responded", i), got, 1'b1);
            if (got) begin
                if (!tbl[i].wr) check($sformatf("v%0d_load", i), load, tbl[i].exp_load);
                check($sformatf("v%0d_latency", i), cyc, tbl[i].exp_cyc);
                check($sformatf("v%0d_strobe_cycles", i), strobe_cnt, tbl[i].exp_strobe);
                check($sformatf("v%0d_ram_addr", i), log_addr[log_addr.size()-1], tbl[i].exp_ram_addr);
                check($sformatf("v%0d_ram_op", i), log_wr[log_wr.size()-1], tbl[i].wr);
                if (tbl[i].wr) check($sformatf("v%0d_ram_store", i), log_store[log_store.size()-1], tbl[i].wdata);
            end
        end
        check("err_after_timeout", err, 1'b1);

        // ---- round robin with both ports pending continuously ----
        do_reset();
        check("err_cleared_by_reset", err, 1'b0);
        ram_lat = 1;
        begin
            int dcnt, icnt, k;
            word_t exp_order[4];
            exp_order[0] = 32'h500; exp_order[1] = 32'h400;
            exp_order[2] = 32'h500; exp_order[3] = 32'h400;
            dcnt = 0; icnt = 0; k = 0;
            n0 = log_addr.size();
            @(posedge CLK); #1;
            iaddr = 32'h400; daddr = 32'h500; iREN = 1'b1; dREN = 1'b1;
            while (log_addr.size() < n0 + 4 && k < 100) begin
                @(negedge CLK);
                k++;
                if (!dwait) dcnt++;
                if (!iwait) icnt++;
            end
            iREN = 1'b0; dREN = 1'b0;
            check("rr_accesses_started", (log_addr.size() >= n0 + 4), 1'b1);
            if (log_addr.size() >= n0 + 4)
                for (int j = 0; j < 4; j++)
                    check($sformatf("rr_grant%0d", j), log_addr[n0+j], exp_order[j]);
            check("rr_d_served", dcnt, 2);
            check("rr_i_served", icnt, 1);
            repeat (6) @(negedge CLK);
        end

        // ---- daddr changes while the read is in flight ----
        ram_lat = 3;
        begin
            bit changed;
            int k;
            changed = 1'b0; got = 1'b0; k = 0;
            n0 = log_addr.size();
            @(posedge CLK); #1;
            daddr = 32'h100; dREN = 1'b1;
            while (!got && k < 100) begin
                @(negedge CLK);
                k++;
                if (!dwait) begin
                    got = 1'b1;
                    load = dload;
                end
                if (ram_ren && !changed) begin
                    daddr = 32'h108;
                    changed = 1'b1;
                end
            end
            dREN = 1'b0;
            check("chg_responded", got, 1'b1);
            check("chg_two_accesses", log_addr.size() - n0, 2);
            if (log_addr.size() >= n0 + 2) begin
                check("chg_first_addr",  log_addr[n0],   32'h100);
                check("chg_second_addr", log_addr[n0+1], 32'h108);
            end
            check("chg_load", load, 32'h0108FEF7);
            repeat (3) @(negedge CLK);
        end

        // ---- RST in the second access cycle, with err set beforehand ----
        ram_lat = 0;
        do_access(1'b0, 1'b0, 32'h700, 32'h0, 0, load, cyc, got);
        check("err_set_again", err, 1'b1);
        ram_lat = 20;
        begin
            int seen, k;
            bit dropped;
            seen = 0; k = 0; dropped = 1'b0;
            @(posedge CLK); #1;
            daddr = 32'h100; dREN = 1'b1;
            while (seen < 2 && k < 100) begin
                @(negedge CLK);
                k++;
                if (ram_ren) seen++;
            end
            check("rstmid_reached_cycle2", seen, 2);
            RST = 1'b1;
            @(negedge CLK);
            check("rstmid_ram_ren", ram_ren, 1'b0);
            check("rstmid_err",     err,     1'b0);
            check("rstmid_dwait",   dwait,   1'b1);
            RST = 1'b0;
            repeat (5) begin
                @(negedge CLK);
                if (!dwait) dropped = 1'b1;
            end
            check("rstmid_no_response", dropped, 1'b0);
            dREN = 1'b0;
            do_reset();
        end

        // ---- randomized traffic vs. memory model ----
        for (int i = 0; i < 40; i++) begin
            bit    is_d, wr;
            word_t a, wd, aw;
            int    lat;
            is_d = 1'($urandom % 2);
            wr   = is_d && ($urandom % 2 == 1);
            a    = 32'h800 + 32'($urandom % 8) * 4 + 32'($urandom % 4);
            aw   = a & 32'hFFFF_FFFC;
            wd   = $urandom;
            lat  = 1 + int'($urandom % 6);
            do_access(is_d, wr, a, wd, lat, load, cyc, got);
            check($sformatf("rnd%0d_responded", i), got, 1'b1);
            if (got) begin
                if (wr) begin
                    ref_mem[aw] = wd;
                    check($sformatf("rnd%0d_ram_store", i), log_store[log_store.size()-1], wd);
                end else begin
                    check($sformatf("rnd%0d_load", i), load, ref_rd(aw));
                end
                check($sformatf("rnd%0d_latency", i), cyc, lat + 2);
                check($sformatf("rnd%0d_ram_addr", i), log_addr[log_addr.size()-1], aw);
                check($sformatf("rnd%0d_ram_op", i), log_wr[log_wr.size()-1], wr);
            end
        end
        check("rnd_err_clear", err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
